ram_march_bist: RTL



---
 rtl/ram_march_bist_if.sv | 44 ++++
 rtl/ram_march_bist.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist_if.sv
// Host/RAM bundle for the March C- BIST initiator.
// Carries the host start/busy/done handshake with the fail report, plus the
// single RAM port (addr/wdata/we driven by the BIST, registered q returned).
//
// Ports (signals):
//   start      host -> bist  one-cycle run request
//   busy       bist -> host  march executing
//   done       bist -> host  one-cycle end-of-test pulse
//   fail       bist -> host  sticky mismatch flag
//   fail_addr  bist -> host  address of first mismatch
//   fail_elem  bist -> host  march element (1..5) of first mismatch
//   ram_addr   bist -> ram   port address
//   ram_wdata  bist -> ram   port write data
//   ram_we     bist -> ram   port write enable
//   ram_q      ram  -> bist  registered read data (one cycle after address)
interface ram_march_bist_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) ();
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [2:0]            fail_elem;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  // master: the BIST engine
  modport master (
    input  start, ram_q,
    output busy, done, fail, fail_addr, fail_elem,
           ram_addr, ram_wdata, ram_we
  );

  // slave: the host and RAM side of the bundle
  modport slave (
    output start, ram_q,
    input  busy, done, fail, fail_addr, fail_elem,
           ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/ram_march_bist.sv
// March C- BIST initiator for one synchronous RAM port, first-fail capture.
// Latency: busy rises 1 cycle after start, lasts 11*N cycles on a pass, done 1 cycle later.
// Backpressure: none; start is sampled only in IDLE and ignored otherwise.
//
// Ports:
//   clk    single clock shared with the RAM
//   rst_n  asynchronous active-low reset (returns to IDLE, clears fail)
//   bus    ram_march_bist_if.master: start/busy/done/fail/fail_addr/fail_elem
//          towards the host, ram_addr/ram_wdata/ram_we/ram_q towards the RAM
module ram_march_bist #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_march_bist_if.master     bus
);

  typedef enum logic [2:0] {
    IDLE,
    W0,
    RD,
    WR,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BG0       = '0;
  localparam logic [DATA_WIDTH-1:0] BG1       = '1;
  localparam logic [2:0]            ELEM_LAST = 3'd5;
  localparam bit                    STOP      = (STOP_ON_FAIL != 0);

  // Elements 3 and 4 walk the address space downwards, all others upwards.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Background each element expects to read back.
  function automatic logic [DATA_WIDTH-1:0] rd_bg(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? BG1 : BG0;
  endfunction

  // Background each element writes after its read (element 5 does not write).
  function automatic logic [DATA_WIDTH-1:0] wr_bg(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? BG1 : BG0;
  endfunction

  state_t                state;
  logic [2:0]            elem;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [2:0]            fail_elem_q;

  logic                  mismatch;
  logic                  at_last;
  logic [2:0]            elem_nxt;

  // In WR, ram_q carries the word fetched by the preceding RD cycle; the
  // RAM's write-through only affects q in the cycle after the write.
  assign mismatch = (bus.ram_q != rd_bg(elem));
  // Element boundaries are detected explicitly, never via counter wrap.
  assign at_last  = elem_down(elem) ? (addr_q == '0) : (addr_q == ADDR_LAST);
  assign elem_nxt = elem + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      elem        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state       <= W0;
            elem        <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= BG0;
            we_q        <= 1'b1;
            busy_q      <= 1'b1;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
          end
        end

        // Element 0: one write of B0 per cycle, ascending.
        W0: begin
          if (addr_q == ADDR_LAST) begin
            state  <= RD;
            elem   <= 3'd1;
            addr_q <= '0;
            we_q   <= 1'b0;
          end else begin
            addr_q <= addr_q + ADDR_ONE;
          end
        end

        // Read issued this cycle; the follow-up WR keeps the address and
        // presents the element's write background.
        RD: begin
          state   <= WR;
          we_q    <= (elem != ELEM_LAST);
          wdata_q <= wr_bg(elem);
        end

        WR: begin
          if (mismatch && !fail_q) begin
            fail_q      <= 1'b1;
            fail_addr_q <= addr_q;
            fail_elem_q <= elem;
          end
          // The write of this WR cycle is already on the bus, so aborting
          // here still lets it complete.
          if ((mismatch && STOP) || (at_last && (elem == ELEM_LAST))) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            we_q   <= 1'b0;
          end else begin
            state <= RD;
            we_q  <= 1'b0;
            if (at_last) begin
              elem   <= elem_nxt;
              addr_q <= elem_down(elem_nxt) ? ADDR_LAST : '0;
            end else if (elem_down(elem)) begin
              addr_q <= addr_q - ADDR_ONE;
            end else begin
              addr_q <= addr_q + ADDR_ONE;
            end
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_elem = fail_elem_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_we    = we_q;

endmodule
